axi_lite_regs: RTL and testbench
================================

AXI_LITE_REGS -- requirements
Module: axi_lite_regs

Interface
REQ-001 SHALL have parameter NUM_CTRL, default 8, number of read/write control registers (1..16).
REQ-002 SHALL have parameter ID_VALUE, default 32'h5A5A_0001, the constant returned at word 0x000.
REQ-003 SHALL have ports aclk in 1 (sole clock) and areset in 1 (asynchronous, active-high reset); all logic is clocked on aclk rising edge.
REQ-004 SHALL have ports s_axi_awaddr in 32, s_axi_awprot in 3 (ignored), s_axi_awvalid in 1, s_axi_awready out 1.
REQ-005 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1.
REQ-006 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-007 SHALL have ports s_axi_araddr in 32, s_axi_arprot in 3 (ignored), s_axi_arvalid in 1, s_axi_arready out 1.
REQ-008 SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-009 SHALL have ports ctrl_regs out NUM_CTRL*32 (register contents), ctrl_wr out NUM_CTRL (one-cycle write pulse per register), stat_in in 16*32 (read-only status words).

Function
REQ-010 SHALL decode word address addr[13:2]; addr[31:14] and addr[1:0] ignored.
REQ-011 SHALL map: 0x000 ID (RO), 0x001 scratch (RW), 0x010..0x010+NUM_CTRL-1 ctrl (RW), 0x020..0x02F stat_in words (RO); all else unmapped.
REQ-012 SHALL implement write FSM W_IDLE -> W_RESP: AW and W captured independently in any order; awready drops after AW capture, wready after W capture; both low in W_RESP.
REQ-013 SHALL, in the cycle after both AW and W are held, update the target register, pulse ctrl_wr for one cycle if ctrl, and assert bvalid (W_RESP).
REQ-014 SHALL hold bvalid/bresp stable until bready; on bvalid&&bready return to W_IDLE with awready=wready=1 next cycle.
REQ-015 SHALL return bresp OKAY for RW hits, SLVERR for writes to RO words (no state change), DECERR for unmapped (no state change).
REQ-016 SHALL implement read FSM R_IDLE -> R_DATA: ar handshake in cycle N gives rvalid, rdata, rresp in N+1; arready low in R_DATA.
REQ-017 SHALL hold rvalid/rdata/rresp stable until rready; arready returns high the cycle after rvalid&&rready.
REQ-018 SHALL return rresp OKAY on mapped reads, DECERR with rdata 32'hDEADBEEF on unmapped reads.
REQ-019 SHALL treat read and write channels independently; a read sampled in the same cycle a write commits returns the pre-write value.
REQ-020 SHALL sample stat_in at the ar handshake cycle.

Reset
REQ-021 SHALL, while areset is high, hold awready, wready, arready, bvalid, rvalid at 0, bresp/rresp at OKAY, rdata at 0, scratch and ctrl_regs at 0, ctrl_wr at 0, both FSMs idle.
REQ-022 SHALL raise awready, wready, arready the first aclk edge after areset deasserts.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation with no register update.

Configuration
REQ-024 SHALL, with AXI_LITE_REGS_WSTRB_EN defined, update only byte lanes whose wstrb bit is 1 (wstrb 4'b0000 gives OKAY, no change, but still pulses ctrl_wr).
REQ-025 SHALL, without AXI_LITE_REGS_WSTRB_EN, ignore wstrb and write the full 32-bit word.

Structure
REQ-026 SHALL take the response codes (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11), map word offsets and the 32'hDEADBEEF sentinel from shared package spi_axi_pkg.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 Write: AW 0x0000_0044 and W 32'h1234_5678 issued together, bready=1 -> bvalid next cycle with OKAY; ctrl_regs word 1 = 32'h1234_5678; ctrl_wr[1] pulses once.
REQ-029 W issued 3 cycles before AW to 0x4 (scratch), with bready held low for 5 cycles -> awready/wready stay low, bvalid and bresp held stable; read of 0x4 returns the data.
REQ-030 Read 0x0 -> rdata ID_VALUE, OKAY; read 0x0000_0400 (unmapped) -> rdata 32'hDEADBEEF, DECERR; write 0x0 -> SLVERR, ID unchanged.
REQ-031 With AXI_LITE_REGS_WSTRB_EN: scratch = 32'hFFFF_FFFF, then write 32'h0 with wstrb 4'b0101 -> readback 32'hFF00_FF00.
REQ-032 Assert areset while AW is captured but W is outstanding -> no register change, all outputs at reset values, ready signals high one cycle after release.

Source files
------------

// File: rtl/spi_axi_pkg.sv
// Shared definitions for the AXI4-Lite register block: response codes,
// register-map word offsets, the unmapped-read sentinel, FSM state types and
// a byte-strobe helper.
// Optional feature macro: AXI_LITE_REGS_WSTRB_EN (uses strb_to_mask).
package spi_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Word offsets (byte address bits [13:2])
   localparam logic [11:0] WORD_ID        = 12'h000;
   localparam logic [11:0] WORD_SCRATCH   = 12'h001;
   localparam logic [11:0] WORD_CTRL_BASE = 12'h010;
   localparam logic [11:0] WORD_STAT_BASE = 12'h020;
   localparam int          NUM_STAT       = 16;

   localparam logic [31:0] DECERR_DATA = 32'hDEADBEEF;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/axi_lite_regs.sv
// AXI4-Lite slave register block.
//   0x000 ID (RO), 0x001 scratch (RW), 0x010.. ctrl[NUM_CTRL] (RW),
//   0x020..0x02F stat_in words (RO); everything else decodes to DECERR.
// Ports:
//   aclk, areset            clock, async active-high reset
//   s_axi_aw*/w*/b*         write address / data / response channels
//   s_axi_ar*/r*            read address / data channels
//   ctrl_regs               ctrl register contents, word i at [i*32 +: 32]
//   ctrl_wr                 one-cycle pulse per ctrl register on write
//   stat_in                 16 read-only status words, word i at [i*32 +: 32]
// Build option: define AXI_LITE_REGS_WSTRB_EN to honour s_axi_wstrb byte
// lanes; otherwise every write replaces the full word.
//
// Write FSM             | Read FSM
//   state  | meaning    |   state  | meaning
//   W_IDLE | collecting AW and W (any order)
//   W_RESP | write done, bvalid held until bready
//   R_IDLE | arready high, waiting for AR
//   R_DATA | rvalid held until rready
module axi_lite_regs
   import spi_axi_pkg::*;
#(
   parameter int          NUM_CTRL = 8,
   parameter logic [31:0] ID_VALUE = 32'h5A5A_0001
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [31:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   input  logic [31:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [NUM_CTRL*32-1:0]   ctrl_regs,
   output logic [NUM_CTRL-1:0]      ctrl_wr,
   input  logic [16*32-1:0]         stat_in
);

   w_state_t                  w_state_q, w_state_d;
   logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic                      awready_q, awready_d, wready_q, wready_d;
   logic [11:0]               awword_q, awword_d;
   logic [31:0]               wdata_q, wdata_d;
   logic                      bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic [31:0]               scratch_q, scratch_d;
   logic [NUM_CTRL-1:0][31:0] ctrl_q, ctrl_d;
   logic [NUM_CTRL-1:0]       ctrl_wr_q, ctrl_wr_d;

   r_state_t                  r_state_q, r_state_d;
   logic                      arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0]               rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;

   logic                      aw_hs, w_hs, wr_commit;
   logic [11:0]               wr_word, ar_word;
   logic [31:0]               wr_data, wr_mask;

`ifdef AXI_LITE_REGS_WSTRB_EN
   logic [3:0]                wstrb_q, wstrb_d;
`else
   logic                      unused_wstrb;
   assign unused_wstrb = ^s_axi_wstrb;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                            s_axi_awaddr[31:14], s_axi_awaddr[1:0],
                            s_axi_araddr[31:14], s_axi_araddr[1:0]};

   // Commit happens on the same edge that completes the second of AW/W, so
   // the write takes either the held copy or the live bus value.
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      awword_d  = awword_q;
      wdata_d   = wdata_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      scratch_d = scratch_q;
      ctrl_d    = ctrl_q;
      ctrl_wr_d = '0;
`ifdef AXI_LITE_REGS_WSTRB_EN
      wstrb_d   = wstrb_q;
      wr_mask   = strb_to_mask(w_held_q ? wstrb_q : s_axi_wstrb);
`else
      wr_mask   = 32'hFFFF_FFFF;
`endif
      aw_hs     = s_axi_awvalid && awready_q;
      w_hs      = s_axi_wvalid && wready_q;
      wr_word   = aw_held_q ? awword_q : s_axi_awaddr[13:2];
      wr_data   = w_held_q ? wdata_q : s_axi_wdata;
      wr_commit = 1'b0;

      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awword_d  = s_axi_awaddr[13:2];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = s_axi_wdata;
`ifdef AXI_LITE_REGS_WSTRB_EN
               wstrb_d  = s_axi_wstrb;
`endif
            end
            wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
            if (wr_commit) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               w_state_d = W_RESP;
               bresp_d   = RESP_DECERR;
               if (wr_word == WORD_ID || wr_word[11:4] == WORD_STAT_BASE[11:4]) begin
                  bresp_d = RESP_SLVERR;
               end else if (wr_word == WORD_SCRATCH) begin
                  bresp_d   = RESP_OKAY;
                  scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
               end
               for (int i = 0; i < NUM_CTRL; i++) begin
                  if (wr_word == WORD_CTRL_BASE + 12'(i)) begin
                     bresp_d      = RESP_OKAY;
                     ctrl_d[i]    = (ctrl_q[i] & ~wr_mask) | (wr_data & wr_mask);
                     ctrl_wr_d[i] = 1'b1;
                  end
               end
            end else begin
               // Also raises the readies on the first edge out of reset.
               awready_d = !aw_held_d;
               wready_d  = !w_held_d;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read mux sees register _q values, so a read sampled on a commit edge
   // returns the pre-write contents.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ar_word   = s_axi_araddr[13:2];

      case (r_state_q)
         R_IDLE: begin
            if (s_axi_arvalid && arready_q) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               r_state_d = R_DATA;
               rdata_d   = DECERR_DATA;
               rresp_d   = RESP_DECERR;
               if (ar_word == WORD_ID) begin
                  rdata_d = ID_VALUE;
                  rresp_d = RESP_OKAY;
               end else if (ar_word == WORD_SCRATCH) begin
                  rdata_d = scratch_q;
                  rresp_d = RESP_OKAY;
               end
               for (int i = 0; i < NUM_CTRL; i++) begin
                  if (ar_word == WORD_CTRL_BASE + 12'(i)) begin
                     rdata_d = ctrl_q[i];
                     rresp_d = RESP_OKAY;
                  end
               end
               for (int i = 0; i < NUM_STAT; i++) begin
                  if (ar_word == WORD_STAT_BASE + 12'(i)) begin
                     rdata_d = stat_in[i*32 +: 32];
                     rresp_d = RESP_OKAY;
                  end
               end
            end else begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         awword_q  <= '0;
         wdata_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         scratch_q <= '0;
         ctrl_q    <= '0;
         ctrl_wr_q <= '0;
`ifdef AXI_LITE_REGS_WSTRB_EN
         wstrb_q   <= '0;
`endif
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         awword_q  <= awword_d;
         wdata_q   <= wdata_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         ctrl_wr_q <= ctrl_wr_d;
`ifdef AXI_LITE_REGS_WSTRB_EN
         wstrb_q   <= wstrb_d;
`endif
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign ctrl_regs     = ctrl_q;
   assign ctrl_wr       = ctrl_wr_q;

endmodule

// File: tb/tb_axi_lite_regs.sv
`timescale 1ns/1ps
module tb_axi_lite_regs;
   localparam int          NUM_CTRL = 8;
   localparam logic [31:0] ID_VALUE = 32'h5A5A_0001;

   logic                   aclk = 1'b0;
   logic                   areset;
   logic [31:0]            s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
   logic [2:0]             s_axi_awprot, s_axi_arprot;
   logic                   s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [3:0]             s_axi_wstrb;
   logic [1:0]             s_axi_bresp, s_axi_rresp;
   logic                   s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic                   s_axi_rvalid, s_axi_rready;
   logic [NUM_CTRL*32-1:0] ctrl_regs;
   logic [NUM_CTRL-1:0]    ctrl_wr;
   logic [16*32-1:0]       stat_in;

   axi_lite_regs #(.NUM_CTRL(NUM_CTRL), .ID_VALUE(ID_VALUE)) dut (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .ctrl_regs(ctrl_regs), .ctrl_wr(ctrl_wr), .stat_in(stat_in)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   // Reference model: register map contents as plain arrays.
   logic [31:0] m_scratch;
   logic [31:0] m_ctrl [NUM_CTRL];
   int          m_wr_cnt [NUM_CTRL];
   int          obs_wr_cnt [NUM_CTRL];
   logic [31:0] stat_words [16];

   always_comb begin
      stat_in = '0;
      for (int i = 0; i < 16; i++) stat_in[i*32 +: 32] = stat_words[i];
   end

   always @(negedge aclk) begin
      for (int i = 0; i < NUM_CTRL; i++) if (ctrl_wr[i] === 1'b1) obs_wr_cnt[i]++;
   end

   function automatic void m_reset();
      m_scratch = '0;
      for (int i = 0; i < NUM_CTRL; i++) m_ctrl[i] = '0;
   endfunction

   function automatic void m_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
      int w = int'(addr[13:2]);
      r = 2'b00;
      if (w == 0) d = ID_VALUE;
      else if (w == 1) d = m_scratch;
      else if (w >= 16 && w < 16 + NUM_CTRL) d = m_ctrl[w-16];
      else if (w >= 32 && w < 48) d = stat_words[w-32];
      else begin d = 32'hDEADBEEF; r = 2'b11; end
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] old_v, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] v = old_v;
`ifdef AXI_LITE_REGS_WSTRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) v[b*8 +: 8] = data[b*8 +: 8];
`else
      v = data;
      if (strb == 4'hF) v = data;
`endif
      return v;
   endfunction

   function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int w = int'(addr[13:2]);
      if (w == 0 || (w >= 32 && w < 48)) return 2'b10;
      if (w == 1) begin m_scratch = m_merge(m_scratch, data, strb); return 2'b00; end
      if (w >= 16 && w < 16 + NUM_CTRL) begin
         m_ctrl[w-16] = m_merge(m_ctrl[w-16], data, strb);
         m_wr_cnt[w-16]++;
         return 2'b00;
      end
      return 2'b11;
   endfunction

   function automatic logic [NUM_CTRL*32-1:0] m_ctrl_vec();
      logic [NUM_CTRL*32-1:0] v;
      for (int i = 0; i < NUM_CTRL; i++) v[i*32 +: 32] = m_ctrl[i];
      return v;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a = $urandom();
      int sel = $urandom_range(0, 9);
      int w;
      case (sel)
         0: w = 0;
         1: w = 1;
         2, 3, 4, 5: w = 16 + $urandom_range(0, NUM_CTRL-1);
         6: w = 32 + $urandom_range(0, 15);
         7: w = $urandom_range(2, 15);
         8: w = $urandom_range(16 + NUM_CTRL, 31);
         default: w = $urandom_range(48, 4095);
      endcase
      a[13:2] = 12'(w);
      return a;
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, fire_aw, fire_w;
      int n = 0;
      s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         fire_aw = s_axi_awvalid && s_axi_awready;
         fire_w  = s_axi_wvalid && s_axi_wready;
         @(posedge aclk); #1; n++;
         if (fire_aw) begin aw_done = 1; s_axi_awvalid = 1'b0; end
         if (fire_w) begin w_done = 1; s_axi_wvalid = 1'b0; end
      end
      n = 0;
      while (s_axi_bvalid !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
      checks++;
      if (s_axi_bvalid !== 1'b1) begin
         errors++;
         $display("FAIL wr_timeout addr=%h bvalid=%b required 1", addr, s_axi_bvalid);
         s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      end
      resp = s_axi_bresp;
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
      bit done = 0, fire;
      int n = 0;
      s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      while (!done && n < 20) begin
         fire = s_axi_arvalid && s_axi_arready;
         @(posedge aclk); #1; n++;
         if (fire) begin done = 1; s_axi_arvalid = 1'b0; end
      end
      n = 0;
      while (s_axi_rvalid !== 1'b1 && n < 20) begin @(posedge aclk); #1; n++; end
      checks++;
      if (s_axi_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL rd_timeout addr=%h rvalid=%b required 1", addr, s_axi_rvalid);
         s_axi_arvalid = 1'b0;
      end
      d = s_axi_rdata; r = s_axi_rresp;
      s_axi_rready = 1'b1;
      @(posedge aclk); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic check_wr_counts(input string tag);
      bit ok = 1;
      for (int i = 0; i < NUM_CTRL; i++) if (obs_wr_cnt[i] != m_wr_cnt[i]) ok = 0;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL %s ctrl_wr pulse counts got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d (idx0..3)", tag,
                  obs_wr_cnt[0], obs_wr_cnt[1], obs_wr_cnt[2], obs_wr_cnt[3],
                  m_wr_cnt[0], m_wr_cnt[1], m_wr_cnt[2], m_wr_cnt[3]);
      end
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      obs = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, |ctrl_wr, |ctrl_regs};
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b required 0000000", obs); end
      checks++;
      if ({s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 36'h0) begin
         errors++; $display("FAIL reset_resp_rdata got %h/%h/%h required 0/0/0", s_axi_bresp, s_axi_rresp, s_axi_rdata);
      end
      areset = 1'b0;
      #1;
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
         errors++; $display("FAIL ready_before_edge got %b required 000", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      @(posedge aclk); #1;
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         errors++; $display("FAIL ready_after_release got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
   endtask

   task automatic test_ctrl_write();
      logic [1:0] er;
      s_axi_awaddr = 32'h0000_0044; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      er = m_write(32'h0000_0044, 32'h1234_5678, 4'hF);
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      checks++;
      if ({s_axi_bvalid, s_axi_bresp} !== {1'b1, er}) begin
         errors++; $display("FAIL ctrl_bvalid_bresp got %b/%b required 1/%b", s_axi_bvalid, s_axi_bresp, er);
      end
      checks++;
      if (ctrl_regs[32 +: 32] !== 32'h1234_5678) begin
         errors++; $display("FAIL ctrl1_value got %h required 12345678", ctrl_regs[32 +: 32]);
      end
      checks++;
      if (ctrl_wr !== 8'b0000_0010) begin errors++; $display("FAIL ctrl_wr_pulse got %b required 00000010", ctrl_wr); end
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
      checks++;
      if ({s_axi_bvalid, ctrl_wr, s_axi_awready, s_axi_wready} !== {1'b0, 8'b0, 2'b11}) begin
         errors++; $display("FAIL ctrl_after_bresp got bvalid=%b ctrl_wr=%b rdy=%b%b required 0/0/11",
                            s_axi_bvalid, ctrl_wr, s_axi_awready, s_axi_wready);
      end
      check_wr_counts("ctrl_write");
   endtask

   task automatic test_w_first();
      logic [31:0] d = $urandom();
      logic [31:0] rd;
      logic [1:0]  rr, er;
      s_axi_wdata = d; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      @(posedge aclk); #1;
      s_axi_wvalid = 1'b0;
      checks++;
      if ({s_axi_wready, s_axi_awready} !== 2'b01) begin
         errors++; $display("FAIL w_first_ready got w=%b aw=%b required 0/1", s_axi_wready, s_axi_awready);
      end
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if ({s_axi_wready, s_axi_bvalid} !== 2'b00) begin
         errors++; $display("FAIL w_first_wait got wready=%b bvalid=%b required 0/0", s_axi_wready, s_axi_bvalid);
      end
      s_axi_awaddr = {$urandom_range(0, 255), 14'h0004}; s_axi_awvalid = 1'b1;
      er = m_write(32'h4, d, 4'hF);
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready} !== {1'b1, er, 2'b00}) begin
            errors++; $display("FAIL b_hold cycle %0d got bvalid=%b bresp=%b rdy=%b%b required 1/%b/00",
                               c, s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, er);
         end
         @(posedge aclk); #1;
      end
      s_axi_bready = 1'b1;
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
      checks++;
      if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
         errors++; $display("FAIL b_release got %b required 011", {s_axi_bvalid, s_axi_awready, s_axi_wready});
      end
      axi_read(32'h4, rd, rr);
      checks++;
      if ({rd, rr} !== {d, 2'b00}) begin errors++; $display("FAIL w_first_readback got %h/%b required %h/00", rd, rr, d); end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic [1:0]  rr, wr;
      axi_read(32'h0, rd, rr);
      checks++;
      if ({rd, rr} !== {ID_VALUE, 2'b00}) begin errors++; $display("FAIL id_read got %h/%b required %h/00", rd, rr, ID_VALUE); end
      axi_read(32'h0000_0400, rd, rr);
      checks++;
      if ({rd, rr} !== {32'hDEADBEEF, 2'b11}) begin errors++; $display("FAIL unmapped_read got %h/%b required deadbeef/11", rd, rr); end
      axi_write(32'h0, 32'hFFFF_0000, 4'hF, wr);
      checks++;
      if (wr !== 2'b10) begin errors++; $display("FAIL id_write_resp got %b required 10", wr); end
      axi_read(32'h0, rd, rr);
      checks++;
      if (rd !== ID_VALUE) begin errors++; $display("FAIL id_unchanged got %h required %h", rd, ID_VALUE); end
   endtask

   task automatic test_wstrb();
      logic [31:0] rd;
      logic [1:0]  rr, wr, er;
      er = m_write(32'h4, 32'hFFFF_FFFF, 4'hF);
      axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, wr);
      er = m_write(32'h4, 32'h0, 4'b0101);
      axi_write(32'h4, 32'h0, 4'b0101, wr);
      axi_read(32'h4, rd, rr);
`ifdef AXI_LITE_REGS_WSTRB_EN
      checks++;
      if (rd !== 32'hFF00_FF00) begin errors++; $display("FAIL wstrb_0101 got %h required ff00ff00", rd); end
      er = m_write(32'h48, 32'hA5A5_A5A5, 4'b0000);
      axi_write(32'h48, 32'hA5A5_A5A5, 4'b0000, wr);
      checks++;
      if ({wr, ctrl_regs[2*32 +: 32]} !== {2'b00, m_ctrl[2]}) begin
         errors++; $display("FAIL wstrb_zero got %b/%h required 00/%h", wr, ctrl_regs[2*32 +: 32], m_ctrl[2]);
      end
`else
      checks++;
      if (rd !== 32'h0000_0000) begin errors++; $display("FAIL wstrb_ignored got %h required 00000000", rd); end
`endif
      check_wr_counts("wstrb");
   endtask

   task automatic test_same_cycle();
      logic [31:0] a = $urandom(), b = $urandom();
      logic [1:0]  wr, er;
      logic [31:0] rd;
      logic [1:0]  rr;
      er = m_write(32'h4, a, 4'hF);
      axi_write(32'h4, a, 4'hF, wr);
      s_axi_awaddr = 32'h4; s_axi_wdata = b; s_axi_wstrb = 4'hF;
      s_axi_araddr = 32'h4;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      checks++;
      if ({s_axi_bvalid, s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {2'b11, 2'b00, a}) begin
         errors++; $display("FAIL same_cycle got b=%b r=%b rresp=%b rdata=%h required 1/1/00/%h",
                            s_axi_bvalid, s_axi_rvalid, s_axi_rresp, s_axi_rdata, a);
      end
      er = m_write(32'h4, b, 4'hF);
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      @(posedge aclk); #1;
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         errors++; $display("FAIL same_cycle_ready got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      axi_read(32'h4, rd, rr);
      checks++;
      if (rd !== b) begin errors++; $display("FAIL same_cycle_new got %h required %h", rd, b); end
   endtask

   task automatic test_random();
      logic [31:0] addr, data, rd, ed;
      logic [3:0]  strb;
      logic [1:0]  rr, er;
      for (int it = 0; it < 80; it++) begin
         addr = rand_addr();
         if ($urandom_range(0, 1) == 1) begin
            data = $urandom();
            strb = 4'($urandom_range(0, 15));
            er = m_write(addr, data, strb);
            axi_write(addr, data, strb, rr);
            checks++;
            if ({rr, ctrl_regs} !== {er, m_ctrl_vec()}) begin
               errors++; $display("FAIL rand_write it=%0d addr=%h got bresp=%b required %b (ctrl match=%b)",
                                  it, addr, rr, er, ctrl_regs === m_ctrl_vec());
            end
         end else begin
            for (int s = 0; s < 16; s++) stat_words[s] = $urandom();
            m_read(addr, ed, er);
            axi_read(addr, rd, rr);
            checks++;
            if ({rd, rr} !== {ed, er}) begin
               errors++; $display("FAIL rand_read it=%0d addr=%h got %h/%b required %h/%b", it, addr, rd, rr, ed, er);
            end
         end
      end
      check_wr_counts("random");
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic [1:0]  rr, er;
      int n = 0;
      bit fire = 0;
      er = m_write(32'h4, 32'h1111_2222, 4'hF);
      axi_write(32'h4, 32'h1111_2222, 4'hF, rr);
      s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
      while (!fire && n < 20) begin
         fire = s_axi_awvalid && s_axi_awready;
         @(posedge aclk); #1; n++;
      end
      s_axi_awvalid = 1'b0;
      checks++;
      if ({s_axi_awready, s_axi_wready} !== 2'b01) begin
         errors++; $display("FAIL mid_aw_held got aw=%b w=%b required 0/1", s_axi_awready, s_axi_wready);
      end
      areset = 1'b1;
      s_axi_wdata = 32'h9999_9999; s_axi_wstrb = 4'hF;
      #1;
      m_reset();
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, ctrl_wr, s_axi_bresp,
           s_axi_rresp, s_axi_rdata, ctrl_regs} !== '0) begin
         errors++; $display("FAIL mid_reset_outputs rdy=%b%b%b bv=%b rv=%b ctrl_wr=%b ctrl=%h required all 0",
                            s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, ctrl_wr, ctrl_regs);
      end
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      s_axi_bready = 1'b0;
      @(posedge aclk); #1;
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b1110) begin
         errors++; $display("FAIL mid_release got %b required 1110",
                            {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
      end
      axi_read(32'h4, rd, rr);
      checks++;
      if (rd !== m_scratch) begin errors++; $display("FAIL mid_no_update got %h required %h", rd, m_scratch); end
      check_wr_counts("reset_mid");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      areset = 1'b1;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      for (int i = 0; i < 16; i++) stat_words[i] = $urandom();
      for (int i = 0; i < NUM_CTRL; i++) begin m_wr_cnt[i] = 0; obs_wr_cnt[i] = 0; end
      m_reset();
      test_reset();
      test_ctrl_write();
      test_w_first();
      test_errors();
      test_wstrb();
      test_same_cycle();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
